operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Sequential front end that sits directly upstream of the ALU/display top.
- Debounces two raw DE2-style push-buttons (active-low) and walks an entry FSM so the user enters operand a, operand b and func one after another from the same switch bank.
- Drives registered a, b and func into the ALU/display top, plus a valid flag and the current entry stage.

Parameters:
- width, 6, operand width; must match the downstream ALU width.
- DB_CYCLES, 50000, number of consecutive clock cycles a synchronized key must differ from its debounced state before the change is accepted (1 ms at 50 MHz). Minimum 2.
- CNT_W, $clog2(DB_CYCLES), width of each debounce counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  width  raw operand switches (static levels, not synchronized by this block).
- func_sw  input  3  raw func switches.
- key_next_n  input  1  raw "next/enter" push-button, low = pressed.
- key_clr_n  input  1  raw "clear" push-button, low = pressed.
- a  output  width  latched operand a.
- b  output  width  latched operand b.
- func  output  3  latched func.
- valid  output  1  high while a/b/func form a complete, consistent set.
- stage  output  2  entry stage: 0 = ENTER_A, 1 = ENTER_B, 2 = ENTER_F, 3 = SHOW.

Behaviour:
- Reset (rst_n low, asynchronous): a = 0, b = 0, func = 0, valid = 0, stage = ENTER_A.
- Reset also clears both synchronizers and debounced states to 1 (released) and both counters to 0. Reset mid-entry discards any partial entry.
- Per key, synchronizer: two flops, reset value 1.
- Per key, debounce counter:
  - Cleared whenever the synchronized level equals the debounced state.
  - Increments each cycle the synchronized level differs from the debounced state.
  - When the count equals DB_CYCLES-1 and the levels still differ, the debounced state takes the synchronized level and the count clears.
- Per key, press event: a one-cycle pulse equal to (debounced state delayed by one cycle) AND NOT (debounced state).
  - Only a release-to-press transition produces an event. Release produces none.
  - Holding a key produces exactly one event.
  - Bounces or glitches shorter than DB_CYCLES synchronized cycles produce no event.
- Latency: raw key low first sampled at edge E0 and held. The FSM acts on the press at edge E0+DB_CYCLES+2.
- FSM transitions on a next press:
  - ENTER_A: a <= sw, go to ENTER_B.
  - ENTER_B: b <= sw, go to ENTER_F.
  - ENTER_F: func <= func_sw, valid <= 1, go to SHOW.
  - SHOW: valid <= 0, go to ENTER_A. a, b and func hold their values until overwritten.
- A clr press in any stage: a = b = func = 0, valid = 0, stage = ENTER_A on that edge.
- Simultaneous next and clr press events in the same cycle: clr wins and next is ignored.
- Switches are sampled only on the capture edge. Switch changes at any other time have no effect on the outputs.
- valid is high only in SHOW, so stage == 3 exactly when valid == 1.
- All outputs are registered, with no combinational path from any input to any output.

Test Plan:
- DB_CYCLES=4: reset, then assert rst_n high -> a=0, b=0, func=0, valid=0, stage=0. Hold this state for 20 cycles with no key activity.
- DB_CYCLES=4: sw=6'd45 and pulse key_next_n low 20 cycles -> at edge E0+6: a=45, stage=1. No further change while held, and no event on release.
- Full entry, DB_CYCLES=4: sw=45 press, sw=6'd3 press, func_sw=3'b011 press -> a=45, b=3, func=3, valid=1, stage=3. One more press -> valid=0, stage=0, with a=45 and b=3 retained.
- Bounce on key_next_n, DB_CYCLES=4: low 2 cycles, high 1, low 3, high 2 -> no event, stage unchanged. Then low 10 cycles -> exactly one capture.
- Clear behaviour:
  - In stage 2 with a=45 and b=3, press key_clr_n -> a=0, b=0, func=0, stage=0, valid=0.
  - Both keys driven low on the same cycle -> clr result only, stage=0.
- Assert rst_n low asynchronously mid-debounce while in stage 1 -> outputs go to reset values immediately without waiting for a clock edge. After release, the held key needs a full fresh DB_CYCLES+2 cycles before it is accepted.

Source files
------------

// File: rtl/operand_loader.sv
// operand_loader: debounces the next/clear push-buttons and steps operand a,
// operand b and func entry from one switch bank into registered ALU inputs.
module operand_loader #(
    parameter int width     = 6,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] sw,
    input  logic [2:0]       func_sw,
    input  logic             key_next_n,
    input  logic             key_clr_n,
    output logic [width-1:0] a,
    output logic [width-1:0] b,
    output logic [2:0]       func,
    output logic             valid,
    output logic [1:0]       stage
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ENTER_F = 2'd2,
        SHOW    = 2'd3
    } stage_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Bit 0 tracks the next key, bit 1 the clear key; all levels are active-low.
    logic [1:0]            raw_s;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            db_q;
    logic [1:0]            db_d;
    logic [1:0]            db_dly_q;
    logic [1:0]            press_s;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    stage_e                state_q;
    logic [width-1:0]      a_q;
    logic [width-1:0]      b_q;
    logic [2:0]            func_q;
    logic                  valid_q;

    assign raw_s   = {key_clr_n, key_next_n};
    assign press_s = db_dly_q & ~db_q;

    // Debounce next-state: count disagreeing cycles, accept after DB_CYCLES of them.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == db_q[k]) begin
                cnt_d[k] = CNT_ZERO;
            end else if (cnt_q[k] == CNT_MAX) begin
                db_d[k]  = sync2_q[k];
                cnt_d[k] = CNT_ZERO;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
    end

    // Key synchronizers, debounced levels and their one-cycle-delayed copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            db_q     <= 2'b11;
            db_dly_q <= 2'b11;
            cnt_q    <= {2{CNT_ZERO}};
        end else begin
            sync1_q  <= raw_s;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Entry FSM; a clear press overrides a next press arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            a_q     <= {width{1'b0}};
            b_q     <= {width{1'b0}};
            func_q  <= 3'd0;
            valid_q <= 1'b0;
        end else if (press_s[1]) begin
            state_q <= ENTER_A;
            a_q     <= {width{1'b0}};
            b_q     <= {width{1'b0}};
            func_q  <= 3'd0;
            valid_q <= 1'b0;
        end else if (press_s[0]) begin
            case (state_q)
                ENTER_A: begin
                    a_q     <= sw;
                    state_q <= ENTER_B;
                end
                ENTER_B: begin
                    b_q     <= sw;
                    state_q <= ENTER_F;
                end
                ENTER_F: begin
                    func_q  <= func_sw;
                    valid_q <= 1'b1;
                    state_q <= SHOW;
                end
                SHOW: begin
                    valid_q <= 1'b0;
                    state_q <= ENTER_A;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ENTER_A;
                end
            endcase
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign func  = func_q;
    assign valid = valid_q;
    assign stage = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed and randomized bench for operand_loader against a cycle-level
// behavioural model of key debouncing and operand entry.
module tb_operand_loader;

    localparam int W  = 6;
    localparam int DB = 4;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic [W-1:0] sw         = 6'd0;
    logic [2:0]   func_sw    = 3'd0;
    logic         key_next_n = 1'b1;
    logic         key_clr_n  = 1'b1;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   func;
    logic         valid;
    logic [1:0]   stage;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: operands, stage number, and per-key view of the raw level two edges late.
    int   ma;
    int   mb;
    int   mf;
    int   mstage;
    logic h1    [2];
    logic h2    [2];
    logic md    [2];
    logic mpend [2];
    int   mrun  [2];

    operand_loader #(.width(W), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .func_sw    (func_sw),
        .key_next_n (key_next_n),
        .key_clr_n  (key_clr_n),
        .a          (a),
        .b          (b),
        .func       (func),
        .valid      (valid),
        .stage      (stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma     = 0;
        mb     = 0;
        mf     = 0;
        mstage = 0;
        for (int k = 0; k < 2; k++) begin
            h1[k]    = 1'b1;
            h2[k]    = 1'b1;
            md[k]    = 1'b1;
            mpend[k] = 1'b0;
            mrun[k]  = 0;
        end
    endtask

    task automatic model_edge();
        logic raw [2];
        logic seen;
        raw[0] = key_next_n;
        raw[1] = key_clr_n;
        if (mpend[1]) begin
            ma     = 0;
            mb     = 0;
            mf     = 0;
            mstage = 0;
        end else if (mpend[0]) begin
            if (mstage == 0) ma = int'(sw);
            else if (mstage == 1) mb = int'(sw);
            else if (mstage == 2) mf = int'(func_sw);
            mstage = (mstage + 1) % 4;
        end
        for (int k = 0; k < 2; k++) begin
            seen     = h2[k];
            h2[k]    = h1[k];
            h1[k]    = raw[k];
            mpend[k] = 1'b0;
            if (seen != md[k]) begin
                mrun[k]++;
                if (mrun[k] == DB) begin
                    md[k]    = seen;
                    mrun[k]  = 0;
                    mpend[k] = !seen;
                end
            end else begin
                mrun[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("a", 32'(a), ma);
        chk("b", 32'(b), mb);
        chk("func", 32'(func), mf);
        chk("valid", 32'(valid), (mstage == 3) ? 32'd1 : 32'd0);
        chk("stage", 32'(stage), mstage);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold_next(input int low, input int high);
        key_next_n = 1'b0;
        repeat (low) cyc();
        key_next_n = 1'b1;
        repeat (high) cyc();
    endtask

    initial begin
        int run_n;
        int run_c;
        model_reset();

        // Reset and idle.
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (20) cyc();
        chk("idle_stage", 32'(stage), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // Single held press: capture lands on edge E0+DB+2.
        sw = 6'd45;
        key_next_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 6) chk("pre_capture_stage", 32'(stage), 32'd0);
            if (i == 7) begin
                chk("capture_a", 32'(a), 32'd45);
                chk("capture_stage", 32'(stage), 32'd1);
            end
        end
        key_next_n = 1'b1;
        repeat (10) cyc();
        chk("release_no_event", 32'(stage), 32'd1);

        // Complete entry, then one more press leaves SHOW.
        sw = 6'd3;
        hold_next(10, 10);
        func_sw = 3'b011;
        hold_next(10, 10);
        chk("full_a", 32'(a), 32'd45);
        chk("full_b", 32'(b), 32'd3);
        chk("full_func", 32'(func), 32'd3);
        chk("full_valid", 32'(valid), 32'd1);
        chk("full_stage", 32'(stage), 32'd3);
        sw = 6'd60;
        hold_next(10, 10);
        chk("show_exit_stage", 32'(stage), 32'd0);
        chk("show_exit_valid", 32'(valid), 32'd0);
        chk("show_exit_a", 32'(a), 32'd45);
        chk("show_exit_b", 32'(b), 32'd3);

        // Bounce shorter than DB cycles, then a clean press.
        sw = 6'd45;
        hold_next(2, 1);
        hold_next(3, 2);
        repeat (6) cyc();
        chk("bounce_stage", 32'(stage), 32'd0);
        hold_next(10, 10);
        chk("clean_after_bounce_stage", 32'(stage), 32'd1);
        chk("clean_after_bounce_a", 32'(a), 32'd45);

        // Clear from ENTER_F.
        sw = 6'd3;
        hold_next(10, 10);
        chk("pre_clr_stage", 32'(stage), 32'd2);
        key_clr_n = 1'b0;
        repeat (10) cyc();
        key_clr_n = 1'b1;
        repeat (10) cyc();
        chk("clr_a", 32'(a), 32'd0);
        chk("clr_b", 32'(b), 32'd0);
        chk("clr_stage", 32'(stage), 32'd0);

        // Simultaneous next and clear: clear wins.
        sw = 6'd7;
        hold_next(10, 10);
        key_next_n = 1'b0;
        key_clr_n  = 1'b0;
        repeat (10) cyc();
        key_next_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (10) cyc();
        chk("both_stage", 32'(stage), 32'd0);
        chk("both_a", 32'(a), 32'd0);

        // Asynchronous reset mid-debounce while in ENTER_B.
        sw = 6'd9;
        hold_next(10, 10);
        key_next_n = 1'b0;
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_a", 32'(a), 32'd0);
        chk("async_rst_stage", 32'(stage), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 6) chk("post_rst_wait_stage", 32'(stage), 32'd0);
            if (i == 7) begin
                chk("post_rst_capture_stage", 32'(stage), 32'd1);
                chk("post_rst_capture_a", 32'(a), 32'd9);
            end
        end
        key_next_n = 1'b1;
        repeat (10) cyc();

        // Randomized key activity and switch churn.
        run_n = 0;
        run_c = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_n == 0) begin
                key_next_n = 1'($urandom_range(0, 1));
                run_n = int'($urandom_range(1, 9));
            end
            if (run_c == 0) begin
                key_clr_n = ($urandom_range(0, 9) != 0);
                run_c = int'($urandom_range(1, 12));
            end
            run_n--;
            run_c--;
            sw      = 6'($urandom);
            func_sw = 3'($urandom);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
